// File: rtl/mc_datapath.sv
// Multi-cycle RV32-style datapath: FETCH/DECODE/EXEC/MEM/WB sequencer with a
// shared memory port, a 32-entry register file and registered ALU result.
module mc_datapath #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 32,
    parameter int ALU_CC_W = 4,
    parameter int RESET_PC = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                reg_write,
    input  logic                mem2reg,
    input  logic                alu_src,
    input  logic                mem_write,
    input  logic                mem_read,
    input  logic                branch,
    input  logic [ALU_CC_W-1:0] alu_cc,
    output logic [6:0]          opcode,
    output logic [6:0]          funct7,
    output logic [2:0]          funct3,
    output logic [DATA_W-1:0]   alu_result,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic [ADDR_W-1:0]   pc,
    output logic                retire
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [ALU_CC_W-1:0] CC_AND = ALU_CC_W'(4'b0000);
    localparam logic [ALU_CC_W-1:0] CC_OR  = ALU_CC_W'(4'b0001);
    localparam logic [ALU_CC_W-1:0] CC_ADD = ALU_CC_W'(4'b0010);
    localparam logic [ALU_CC_W-1:0] CC_SUB = ALU_CC_W'(4'b0110);
    localparam logic [ALU_CC_W-1:0] CC_SLT = ALU_CC_W'(4'b0111);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

    logic [2:0]               state;
    logic [31:0]              ir;
    logic signed [DATA_W-1:0] a_q;
    logic signed [DATA_W-1:0] b_q;
    logic signed [DATA_W-1:0] imm_q;
    logic signed [DATA_W-1:0] alu_out;
    logic signed [DATA_W-1:0] mdr;
    logic signed [DATA_W-1:0] rf [32];

    // Immediate format follows the opcode: S for stores, B for branches, I otherwise.
    function automatic logic signed [DATA_W-1:0] imm_gen(input logic [31:0] i);
        logic signed [31:0] v;
        case (i[6:0])
            7'b0100011: v = {{20{i[31]}}, i[31:25], i[11:7]};
            7'b1100011: v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default:    v = {{20{i[31]}}, i[31:20]};
        endcase
        return DATA_W'(v);
    endfunction

    function automatic logic signed [DATA_W-1:0] alu_op(input logic [ALU_CC_W-1:0] cc,
                                                       input logic signed [DATA_W-1:0] x,
                                                       input logic signed [DATA_W-1:0] y);
        case (cc)
            CC_AND:  return x & y;
            CC_OR:   return x | y;
            CC_ADD:  return x + y;
            CC_SUB:  return x - y;
            CC_SLT:  return (x < y) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
            default: return '0;
        endcase
    endfunction

    assign opcode     = ir[6:0];
    assign funct3     = ir[14:12];
    assign funct7     = ir[31:25];
    assign alu_result = alu_out;
    assign mem_req    = (state == S_FETCH) || (state == S_MEM);
    assign mem_we     = (state == S_MEM) && mem_write;
    assign mem_addr   = (state == S_MEM) ? alu_out[ADDR_W-1:0] : pc;
    assign mem_wdata  = b_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            pc      <= PC_INIT;
            ir      <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            alu_out <= '0;
            mdr     <= '0;
            retire  <= 1'b0;
            for (int r = 0; r < 32; r++) rf[r] <= '0;
        end else begin
            retire <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (mem_ack) begin
                        ir    <= mem_rdata[31:0];
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q   <= (ir[19:15] == 5'd0) ? '0 : rf[ir[19:15]];
                    b_q   <= (ir[24:20] == 5'd0) ? '0 : rf[ir[24:20]];
                    imm_q <= imm_gen(ir);
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    alu_out <= alu_op(alu_cc, a_q, alu_src ? imm_q : b_q);
                    // Branches resolve here and skip MEM/WB entirely.
                    if (branch) begin
                        pc     <= (a_q == b_q) ? pc + imm_q[ADDR_W-1:0] : pc + PC_STEP;
                        retire <= 1'b1;
                        state  <= S_FETCH;
                    end else if (mem_read || mem_write) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mdr   <= mem_rdata;
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    if (reg_write && (ir[11:7] != 5'd0))
                        rf[ir[11:7]] <= mem2reg ? mdr : alu_out;
                    pc     <= pc + PC_STEP;
                    retire <= 1'b1;
                    state  <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: behavioural memory with programmable wait states,
// instructions placed at the model PC, results checked through a scoreboard.
module tb_mc_datapath;

    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    // {reg_write, mem2reg, alu_src, mem_write, mem_read, branch}
    localparam logic [5:0] C_ALUI  = 6'b101000;
    localparam logic [5:0] C_ALUR  = 6'b100000;
    localparam logic [5:0] C_LOAD  = 6'b111010;
    localparam logic [5:0] C_STORE = 6'b001100;
    localparam logic [5:0] C_BR    = 6'b000001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reg_write = 1'b0, mem2reg = 1'b0, alu_src = 1'b0;
    logic        mem_write = 1'b0, mem_read = 1'b0, branch = 1'b0;
    logic [3:0]  alu_cc = 4'b0;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] alu_result, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_req, mem_we, retire;
    logic        mem_ack = 1'b0;
    logic [8:0]  mem_addr, pc;

    logic [31:0] mem [128];
    int wait_cycles = 0;
    int wait_cnt = 0;
    int n_tests = 0;
    int n_fail = 0;
    int mpc = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    mc_datapath dut (
        .clk(clk), .reset(reset),
        .reg_write(reg_write), .mem2reg(mem2reg), .alu_src(alu_src),
        .mem_write(mem_write), .mem_read(mem_read), .branch(branch),
        .alu_cc(alu_cc), .opcode(opcode), .funct7(funct7), .funct3(funct3),
        .alu_result(alu_result), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .pc(pc), .retire(retire)
    );

    always #5 clk = ~clk;

    // Memory answers after wait_cycles stalled cycles of a request.
    always @(negedge clk) begin
        if (mem_req && wait_cnt >= wait_cycles) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr[8:2]];
            if (mem_we) mem[mem_addr[8:2]] = mem_wdata;
            wait_cnt  = 0;
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
            if (mem_req) wait_cnt++;
        end
    end

    function automatic logic [31:0] enc_i(int imm, int rs1, logic [2:0] f3, int rd, logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3, rd[4:0], op};
    endfunction

    function automatic logic [31:0] enc_r(logic [6:0] f7, int rs2, int rs1, logic [2:0] f3, int rd);
        return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    // Places one instruction at the model PC and runs it to retirement.
    task automatic run_instr(input logic [31:0] instr, input logic [5:0] ctl, input logic [3:0] cc,
                             input int daddr, output int cyc, output int hold,
                             output logic seen_we, output logic [31:0] seen_wdata);
        mem[mpc[8:2]] = instr;
        {reg_write, mem2reg, alu_src, mem_write, mem_read, branch} = ctl;
        alu_cc = cc;
        cyc = 0; hold = 0; seen_we = 1'b0; seen_wdata = 32'h0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (mem_req && int'(mem_addr) == daddr) begin
                hold++;
                if (mem_we) begin
                    seen_we = 1'b1;
                    seen_wdata = mem_wdata;
                end
            end
        end while (!retire && cyc < 60);
        if (!retire) begin
            n_tests++; n_fail++;
            $display("FAIL retire_timeout instr=%h got no retire exp retire within 60 cycles", instr);
        end
    endtask

    task automatic step(input logic [31:0] instr, input logic [5:0] ctl, input logic [3:0] cc,
                        output int cyc);
        int h; logic w; logic [31:0] d;
        run_instr(instr, ctl, cc, -1, cyc, h, w, d);
    endtask

    // Reads a register through addi x0, xr, 0 and the registered ALU result.
    task automatic read_reg(input int r, output logic [31:0] v);
        int c;
        step(enc_i(0, r, 3'b000, 0, OP_I), C_ALUI, 4'b0010, c);
        mpc = (mpc + 4) & 511;
        v = alu_result;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL reset_mem_req got %b exp 1", mem_req); end
        n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
        n_tests++; if (mem_addr !== 9'd0) begin n_fail++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
        n_tests++; if (pc !== 9'd0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", pc); end
        n_tests++; if ({mem_wdata, alu_result} !== 64'h0) begin n_fail++; $display("FAIL reset_data got %h/%h exp 0/0", mem_wdata, alu_result); end
        n_tests++; if (retire !== 1'b0) begin n_fail++; $display("FAIL reset_retire got %b exp 0", retire); end
        n_tests++; if ({opcode, funct7, funct3} !== 17'h0) begin n_fail++; $display("FAIL reset_ir_fields got %h exp 0", {opcode, funct7, funct3}); end
        reset = 1'b0;
        wait_cnt = 0;
        mpc = 0;
    endtask

    task automatic test_addi();
        int c; logic [31:0] v; exp_t e;
        wait_cycles = 0;
        sb.push_back('{"addi_alu", 32'd5});
        step(enc_i(5, 0, 3'b000, 1, OP_I), C_ALUI, 4'b0010, c);
        mpc = (mpc + 4) & 511;
        e = sb.pop_front();
        n_tests++; if (alu_result !== e.val) begin n_fail++; $display("FAIL %s got %h exp %h", e.tag, alu_result, e.val); end
        n_tests++; if (c !== 4) begin n_fail++; $display("FAIL addi_latency got %0d exp 4", c); end
        n_tests++; if (pc !== 9'd4) begin n_fail++; $display("FAIL addi_pc got %h exp 004", pc); end
        n_tests++; if (opcode !== OP_I) begin n_fail++; $display("FAIL addi_opcode got %b exp %b", opcode, OP_I); end
        sb.push_back('{"addi_x1", 32'd5});
        read_reg(1, v);
        e = sb.pop_front();
        n_tests++; if (v !== e.val) begin n_fail++; $display("FAIL %s got %h exp %h", e.tag, v, e.val); end
    endtask

    task automatic test_alu_ops();
        logic [3:0]  cc_t [6] = '{4'b0110, 4'b0111, 4'b0111, 4'b0000, 4'b0001, 4'b0011};
        logic [6:0]  f7_t [6] = '{7'b0100000, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0};
        logic [2:0]  f3_t [6] = '{3'b000, 3'b010, 3'b010, 3'b111, 3'b110, 3'b001};
        int          s1_t [6] = '{3, 2, 3, 3, 3, 3};
        int          s2_t [6] = '{2, 3, 2, 2, 2, 2};
        logic [31:0] ex_t [6] = '{32'd13, 32'd1, 32'd0, 32'd8, 32'hFFFF_FFFF, 32'd0};
        int c; logic [31:0] v; exp_t e;
        step(enc_i(-3, 0, 3'b000, 2, OP_I), C_ALUI, 4'b0010, c); mpc = (mpc + 4) & 511;
        step(enc_i(10, 0, 3'b000, 3, OP_I), C_ALUI, 4'b0010, c); mpc = (mpc + 4) & 511;
        for (int k = 0; k < 6; k++) begin
            sb.push_back('{$sformatf("alu_op%0d", k), ex_t[k]});
            step(enc_r(f7_t[k], s2_t[k], s1_t[k], f3_t[k], 4 + k), C_ALUR, cc_t[k], c);
            mpc = (mpc + 4) & 511;
            e = sb.pop_front();
            n_tests++; if (alu_result !== e.val) begin n_fail++; $display("FAIL %s got %h exp %h", e.tag, alu_result, e.val); end
        end
        n_tests++; if (funct3 !== 3'b001) begin n_fail++; $display("FAIL funct3_field got %b exp 001", funct3); end
        sb.push_back('{"sub_wb_x4", 32'd13});
        read_reg(4, v);
        e = sb.pop_front();
        n_tests++; if (v !== e.val) begin n_fail++; $display("FAIL %s got %h exp %h", e.tag, v, e.val); end
    endtask

    task automatic test_load();
        int c, h; logic w; logic [31:0] d, v; exp_t e;
        int exp_pc;
        wait_cycles = 3;
        mem[2] = 32'hDEAD_BEEF;
        exp_pc = (mpc + 4) & 511;
        run_instr(enc_i(8, 0, 3'b010, 2, OP_LD), C_LOAD, 4'b0010, 8, c, h, w, d);
        mpc = exp_pc;
        n_tests++; if (h !== 4) begin n_fail++; $display("FAIL load_addr_hold got %0d exp 4", h); end
        n_tests++; if (c !== 11) begin n_fail++; $display("FAIL load_latency_waits got %0d exp 11", c); end
        n_tests++; if (int'(pc) !== exp_pc) begin n_fail++; $display("FAIL load_pc got %h exp %h", pc, exp_pc); end
        wait_cycles = 0;
        sb.push_back('{"load_x2", 32'hDEAD_BEEF});
        read_reg(2, v);
        e = sb.pop_front();
        n_tests++; if (v !== e.val) begin n_fail++; $display("FAIL %s got %h exp %h", e.tag, v, e.val); end
    endtask

    task automatic test_store();
        int c, h; logic w; logic [31:0] d, v; exp_t e;
        mem[3] = 32'h1234_5678;
        step(enc_i(12, 0, 3'b010, 1, OP_LD), C_LOAD, 4'b0010, c); mpc = (mpc + 4) & 511;
        n_tests++; if (c !== 5) begin n_fail++; $display("FAIL load_latency got %0d exp 5", c); end
        run_instr(enc_s(4, 1, 0), C_STORE, 4'b0010, 4, c, h, w, d);
        mpc = (mpc + 4) & 511;
        n_tests++; if (w !== 1'b1 || h !== 1) begin n_fail++; $display("FAIL store_we got we=%b cycles=%0d exp we=1 cycles=1", w, h); end
        n_tests++; if (d !== 32'h1234_5678) begin n_fail++; $display("FAIL store_wdata got %h exp 12345678", d); end
        n_tests++; if (mem[1] !== 32'h1234_5678) begin n_fail++; $display("FAIL store_mem got %h exp 12345678", mem[1]); end
        n_tests++; if (c !== 5) begin n_fail++; $display("FAIL store_latency got %0d exp 5", c); end
        sb.push_back('{"store_no_rf_x4", 32'd13});
        read_reg(4, v);
        e = sb.pop_front();
        n_tests++; if (v !== e.val) begin n_fail++; $display("FAIL %s got %h exp %h", e.tag, v, e.val); end
    endtask

    task automatic test_wrap_x0();
        int c;
        step(enc_b(32'h1FC - mpc, 0, 0), C_BR, 4'b0110, c);
        mpc = 32'h1FC;
        n_tests++; if (pc !== 9'h1FC || c !== 3) begin n_fail++; $display("FAIL jump_1fc got pc=%h cyc=%0d exp pc=1fc cyc=3", pc, c); end
        step(enc_i(9, 0, 3'b000, 0, OP_I), C_ALUI, 4'b0010, c);
        mpc = (mpc + 4) & 511;
        n_tests++; if (int'(pc) !== mpc || alu_result !== 32'd9) begin n_fail++; $display("FAIL pc_wrap got pc=%h alu=%h exp pc=%h alu=9", pc, alu_result, mpc); end
    endtask

    task automatic test_branch();
        int c; logic [31:0] v; exp_t e;
        step(enc_i(7, 0, 3'b000, 1, OP_I), C_ALUI, 4'b0010, c); mpc = (mpc + 4) & 511;
        step(enc_i(7, 0, 3'b000, 2, OP_I), C_ALUI, 4'b0010, c); mpc = (mpc + 4) & 511;
        step(enc_b(-4, 2, 1), C_BR, 4'b0110, c);
        mpc = (mpc - 4) & 511;
        n_tests++; if (int'(pc) !== mpc || pc !== 9'd4) begin n_fail++; $display("FAIL beq_taken_pc got %h exp 004", pc); end
        n_tests++; if (c !== 3) begin n_fail++; $display("FAIL beq_latency got %0d exp 3", c); end
        step(enc_i(6, 0, 3'b000, 2, OP_I), C_ALUI, 4'b0010, c); mpc = (mpc + 4) & 511;
        step(enc_b(-4, 2, 1), C_BR, 4'b0110, c);
        mpc = (mpc + 4) & 511;
        n_tests++; if (int'(pc) !== mpc || pc !== 9'd12) begin n_fail++; $display("FAIL beq_not_taken_pc got %h exp 00c", pc); end
        sb.push_back('{"x0_reads_zero", 32'd0});
        read_reg(0, v);
        e = sb.pop_front();
        n_tests++; if (v !== e.val) begin n_fail++; $display("FAIL %s got %h exp %h", e.tag, v, e.val); end
    endtask

    task automatic test_reset_mid();
        int n; logic [31:0] v; exp_t e;
        wait_cycles = 0;
        mem[2] = 32'hDEAD_BEEF;
        mem[mpc[8:2]] = enc_i(8, 0, 3'b010, 3, OP_LD);
        {reg_write, mem2reg, alu_src, mem_write, mem_read, branch} = C_LOAD;
        alu_cc = 4'b0010;
        @(posedge clk); #1;
        wait_cycles = 100;
        n = 0;
        while (!(mem_req && mem_addr == 9'd8) && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        n_tests++; if (n >= 10) begin n_fail++; $display("FAIL mid_reach_mem got no MEM request exp mem_addr=008"); end
        @(posedge clk); #1;
        reset = 1'b1;
        wait_cycles = 0;
        @(posedge clk); #1;
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 9'd0 || pc !== 9'd0) begin n_fail++; $display("FAIL mid_reset_fetch got req=%b addr=%h pc=%h exp 1/000/000", mem_req, mem_addr, pc); end
        n_tests++; if (retire !== 1'b0 || alu_result !== 32'd0) begin n_fail++; $display("FAIL mid_reset_state got retire=%b alu=%h exp 0/0", retire, alu_result); end
        reset = 1'b0;
        wait_cnt = 0;
        mpc = 0;
        sb.push_back('{"mid_reset_x3", 32'd0});
        read_reg(3, v);
        e = sb.pop_front();
        n_tests++; if (v !== e.val) begin n_fail++; $display("FAIL %s got %h exp %h", e.tag, v, e.val); end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        test_reset();
        test_addi();
        test_alu_ops();
        test_load();
        test_store();
        test_wrap_x0();
        test_branch();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion exp finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
